// File: rtl/si_tx_ctrl.sv
// si_tx_ctrl: transmit controller for the serial interface.
// Buffers one parallel word in a holding register and sequences the
// parallel-load / shift-enable strobes of the downstream shift_reg so the word
// leaves LSB first, one bit every DIV clocks. Back-to-back words are chained
// with no idle bit by reloading the shift register in the last bit period.
module si_tx_ctrl #(
   parameter int SSIZE = 16,
   parameter int DIV   = 4
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [SSIZE-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [SSIZE-1:0] sr_in,
   output logic             sr_load,
   output logic             sr_en,
   output logic             sr_frame,
   output logic             tx_done
);

   localparam int BIT_W = $clog2(SSIZE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SSIZE - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [SSIZE-1:0]   hold_q, hold_d;
   logic               hold_full_q, hold_full_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;

   logic               accept;
   logic               last_period;
   logic               last_bit;

   // Holding register is the only thing that looks at tx_valid/tx_data;
   // all strobes below decode purely from registered state.
   assign accept      = tx_valid && !hold_full_q;
   assign last_period = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);
   assign last_bit    = (bit_cnt_q == BIT_LAST);

   assign tx_ready = !hold_full_q;
   assign sr_in    = hold_q;

   // Next-state and strobe decode for the IDLE/SHIFT sequencer and the hold register.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;
      sr_load     = 1'b0;
      sr_en       = 1'b0;
      sr_frame    = 1'b0;
      tx_done     = 1'b0;

      case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               sr_load   = 1'b1;
               bit_cnt_d = '0;
               div_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            sr_frame = 1'b1;
            if (last_period) begin
               // With DIV=1 every SHIFT cycle lands here, so div_cnt stays at 0.
               div_cnt_d = '0;
               if (!last_bit) begin
                  sr_en     = 1'b1;
                  bit_cnt_d = bit_cnt_q + BIT_ONE;
               end else begin
                  tx_done   = 1'b1;
                  bit_cnt_d = '0;
                  if (hold_full_q) begin
                     // Chain the next word: reload instead of shifting, frame stays high.
                     sr_load = 1'b1;
                  end else begin
                     // Final shift empties the shift register so sr_out idles at 0.
                     sr_en   = 1'b1;
                     state_d = IDLE;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A load drains the holding register; accept and drain never coincide
      // because a drain needs hold_full_q=1, which blocks accept.
      if (sr_load) begin
         hold_full_d = 1'b0;
      end
      if (accept) begin
         hold_full_d = 1'b1;
         hold_d      = tx_data;
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         div_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         div_cnt_q   <= div_cnt_d;
      end
   end

endmodule

// File: tb/tb_si_tx_ctrl.sv
// Directed bench for si_tx_ctrl: one DIV=4 instance and one DIV=1 instance,
// each feeding a small behavioural shift register so the serial bit stream
// can be reconstructed and compared with hand-computed words.
module tb_si_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   always #5 clk = ~clk;

   logic [15:0] a_data, a_sr_in;
   logic        a_valid, a_ready, a_load, a_en, a_frame, a_done;
   logic [15:0] b_data, b_sr_in;
   logic        b_valid, b_ready, b_load, b_en, b_frame, b_done;

   si_tx_ctrl #(.SSIZE(16), .DIV(4)) dut_a (
      .rclk     (clk),
      .rrst_n   (rst_n),
      .tx_data  (a_data),
      .tx_valid (a_valid),
      .tx_ready (a_ready),
      .sr_in    (a_sr_in),
      .sr_load  (a_load),
      .sr_en    (a_en),
      .sr_frame (a_frame),
      .tx_done  (a_done)
   );

   si_tx_ctrl #(.SSIZE(16), .DIV(1)) dut_b (
      .rclk     (clk),
      .rrst_n   (rst_n),
      .tx_data  (b_data),
      .tx_valid (b_valid),
      .tx_ready (b_ready),
      .sr_in    (b_sr_in),
      .sr_load  (b_load),
      .sr_en    (b_en),
      .sr_frame (b_frame),
      .tx_done  (b_done)
   );

   // Behavioural downstream shift registers; sr_out is bit 0.
   logic [15:0] mod_a, mod_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mod_a <= '0;
         mod_b <= '0;
      end else begin
         if (a_load)    mod_a <= a_sr_in;
         else if (a_en) mod_a <= {1'b0, mod_a[15:1]};
         if (b_load)    mod_b <= b_sr_in;
         else if (b_en) mod_b <= {1'b0, mod_b[15:1]};
      end
   end

   // Cumulative strobe statistics, sampled on the falling edge.
   int mcyc = 0;
   int en_a = 0, load_a = 0, done_a = 0, gap_a = 0, both_a = 0, strobe_a = 0;
   int frun_a = 0, lastrun_a = 0, nb_a = 0, dprev_a = 0, dlast_a = 0, loadpos_a = 0;
   int en_b = 0, done_b = 0, gap_b = 0, strobe_b = 0;
   int frun_b = 0, lastrun_b = 0, nb_b = 0;
   logic [255:0] bits_a = '0;
   logic [255:0] bits_b = '0;

   always @(negedge clk) begin
      mcyc <= mcyc + 1;
   end

   always @(negedge clk) begin
      if (a_en) begin
         en_a     <= en_a + 1;
         strobe_a <= mcyc;
         if (mcyc - strobe_a != 4) gap_a <= gap_a + 1;
      end
      if (a_load) begin
         load_a   <= load_a + 1;
         strobe_a <= mcyc;
         if (a_frame) loadpos_a <= frun_a + 1;
      end
      if (a_load && a_en) both_a <= both_a + 1;
      if (a_done) begin
         done_a  <= done_a + 1;
         dprev_a <= dlast_a;
         dlast_a <= mcyc;
      end
      if (a_frame) begin
         if (frun_a % 4 == 0) begin
            bits_a[nb_a] <= mod_a[0];
            nb_a         <= nb_a + 1;
         end
         frun_a <= frun_a + 1;
      end else begin
         if (frun_a != 0) lastrun_a <= frun_a;
         frun_a <= 0;
      end
   end

   always @(negedge clk) begin
      if (b_en) begin
         en_b     <= en_b + 1;
         strobe_b <= mcyc;
         if (mcyc - strobe_b != 1) gap_b <= gap_b + 1;
      end
      if (b_load) strobe_b <= mcyc;
      if (b_done) done_b <= done_b + 1;
      if (b_frame) begin
         bits_b[nb_b] <= mod_b[0];
         nb_b         <= nb_b + 1;
         frun_b       <= frun_b + 1;
      end else begin
         if (frun_b != 0) lastrun_b <= frun_b;
         frun_b <= 0;
      end
   end

   int total  = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] word_a(input int base);
      logic [15:0] w;
      for (int i = 0; i < 16; i++) w[i] = bits_a[base + i];
      return w;
   endfunction

   function automatic logic [15:0] word_b(input int base);
      logic [15:0] w;
      for (int i = 0; i < 16; i++) w[i] = bits_b[base + i];
      return w;
   endfunction

   int base, e0, l0, d0, g0;

   initial begin
      // Reset with a handshake offered: nothing may be taken.
      a_valid = 1'b1;
      a_data  = 16'h1234;
      b_valid = 1'b0;
      b_data  = 16'h0000;
      rst_n   = 1'b0;
      tick(3);
      chk("rst_sr_in", a_sr_in, 16'h0000);
      chk("rst_sr_load", a_load, 1'b0);
      chk("rst_sr_en", a_en, 1'b0);
      chk("rst_sr_frame", a_frame, 1'b0);
      chk("rst_tx_done", a_done, 1'b0);
      chk("rst_tx_ready", a_ready, 1'b1);
      a_valid = 1'b0;
      rst_n   = 1'b1;
      tick(2);
      chk("post_rst_ready", a_ready, 1'b1);
      chk("post_rst_load", a_load, 1'b0);
      chk("post_rst_sr_in", a_sr_in, 16'h0000);
      chk("post_rst_frame", a_frame, 1'b0);

      // Single word 16'hA5C3 at DIV=4.
      base = nb_a; e0 = en_a; l0 = load_a; d0 = done_a; g0 = gap_a;
      a_data  = 16'hA5C3;
      a_valid = 1'b1;
      tick(1);
      chk("single_load_after_accept", a_load, 1'b1);
      chk("single_ready_low", a_ready, 1'b0);
      chk("single_sr_in", a_sr_in, 16'hA5C3);
      chk("single_frame_not_yet", a_frame, 1'b0);
      a_valid = 1'b0;
      tick(1);
      chk("single_frame_rise", a_frame, 1'b1);
      chk("single_load_one_cycle", a_load, 1'b0);
      chk("single_ready_back", a_ready, 1'b1);
      tick(80);
      chk("single_en_count", en_a - e0, 16);
      chk("single_load_count", load_a - l0, 1);
      chk("single_done_count", done_a - d0, 1);
      chk("single_frame_len", lastrun_a, 64);
      chk("single_en_spacing", gap_a - g0, 0);
      chk("single_bit_count", nb_a - base, 16);
      chk("single_bits", word_a(base), 16'hA5C3);
      chk("single_flushed", mod_a, 16'h0000);
      chk("single_frame_low", a_frame, 1'b0);

      // Back-to-back 16'hFFFF then 16'h0001, second offered immediately.
      base = nb_a; e0 = en_a; l0 = load_a; d0 = done_a; g0 = gap_a;
      a_data  = 16'hFFFF;
      a_valid = 1'b1;
      tick(1);
      a_data  = 16'h0001;
      tick(1);
      chk("b2b_ready_second", a_ready, 1'b1);
      tick(1);
      a_valid = 1'b0;
      chk("b2b_second_held", a_ready, 1'b0);
      tick(150);
      chk("b2b_frame_len", lastrun_a, 128);
      chk("b2b_done_count", done_a - d0, 2);
      chk("b2b_done_gap", dlast_a - dprev_a, 64);
      chk("b2b_load_count", load_a - l0, 2);
      chk("b2b_en_count", en_a - e0, 31);
      chk("b2b_load_pos", loadpos_a, 64);
      chk("b2b_load_en_overlap", both_a, 0);
      chk("b2b_en_spacing", gap_a - g0, 0);
      chk("b2b_word0", word_a(base), 16'hFFFF);
      chk("b2b_word1", word_a(base + 16), 16'h0001);

      // DIV=1 instance, word 16'h8001.
      base = nb_b; e0 = en_b; d0 = done_b; g0 = gap_b;
      b_data  = 16'h8001;
      b_valid = 1'b1;
      tick(1);
      b_valid = 1'b0;
      tick(30);
      chk("div1_en_count", en_b - e0, 16);
      chk("div1_frame_len", lastrun_b, 16);
      chk("div1_done_count", done_b - d0, 1);
      chk("div1_en_spacing", gap_b - g0, 0);
      chk("div1_bits", word_b(base), 16'h8001);

      // Reset during bit 7 of a word, then a clean word.
      d0 = done_a;
      a_data  = 16'h1234;
      a_valid = 1'b1;
      tick(1);
      a_valid = 1'b0;
      tick(30);
      chk("midrst_frame_before", a_frame, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_frame", a_frame, 1'b0);
      chk("midrst_load", a_load, 1'b0);
      chk("midrst_en", a_en, 1'b0);
      chk("midrst_done", a_done, 1'b0);
      chk("midrst_ready", a_ready, 1'b1);
      chk("midrst_sr_in", a_sr_in, 16'h0000);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("midrst_no_done", done_a - d0, 0);
      base = nb_a; d0 = done_a;
      a_data  = 16'h00FF;
      a_valid = 1'b1;
      tick(1);
      a_valid = 1'b0;
      tick(80);
      chk("after_rst_bits", word_a(base), 16'h00FF);
      chk("after_rst_done", done_a - d0, 1);
      chk("after_rst_frame_len", lastrun_a, 64);

      // Stall: tx_valid held, tx_data changing every cycle.
      base = nb_a; d0 = done_a;
      a_data  = 16'h1111;
      a_valid = 1'b1;
      tick(1);
      chk("stall_ready_low", a_ready, 1'b0);
      a_data = 16'h2222;
      tick(1);
      chk("stall_ready_high", a_ready, 1'b1);
      chk("stall_hold_first", a_sr_in, 16'h1111);
      a_data = 16'h3333;
      tick(1);
      chk("stall_captured", a_sr_in, 16'h3333);
      for (int i = 0; i < 40; i++) begin
         a_data = 16'h4000 + 16'(i);
         tick(1);
         chk($sformatf("stall_sr_in_%0d", i), a_sr_in, 16'h3333);
      end
      a_valid = 1'b0;
      tick(100);
      chk("stall_word0", word_a(base), 16'h1111);
      chk("stall_word1", word_a(base + 16), 16'h3333);
      chk("stall_bit_count", nb_a - base, 32);
      chk("stall_done_count", done_a - d0, 2);
      chk("stall_frame_len", lastrun_a, 128);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
